// File: rtl/seven_segment_scanner.sv
// Time-multiplexed scan controller for a multi-digit seven-segment display sharing one BCD decoder.
// Double-buffered BCD value: new loads are promoted to the display only at the frame boundary.
module seven_segment_scanner #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned BLANK    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  zero_suppress,
  output logic [3:0]            bcd,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  pending,
  output logic                  frame_start
);

  localparam int unsigned CW = $clog2(PRESCALE);
  localparam int unsigned SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(DIGITS - 1);

  logic [CW-1:0]       r_cnt;
  logic [SW-1:0]       r_slot;
  logic [4*DIGITS-1:0] r_active;
  logic [4*DIGITS-1:0] r_shadow;
  logic                r_pending;

  logic                w_cnt_last;
  logic                w_boundary;
  logic                w_show;
  logic [DIGITS-1:0]   w_nz;
  logic [DIGITS-1:0]   w_suppress;
  logic [4*DIGITS-1:0] w_shifted;

  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_boundary = w_cnt_last && (r_slot == SLOT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_slot <= '0;
    end else if (w_cnt_last) begin
      r_cnt  <= '0;
      r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A load coinciding with the frame boundary bypasses the shadow and is shown immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else if (w_boundary) begin
      if (load) begin
        r_active  <= value;
        r_shadow  <= value;
        r_pending <= 1'b0;
      end else if (r_pending) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
      end
    end else if (load) begin
      r_shadow  <= value;
      r_pending <= 1'b1;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_nz
    assign w_nz[g] = |r_active[4*g +: 4];
  end

  // Digit g is a leading zero when it and every more-significant digit is zero.
  assign w_suppress[0] = 1'b0;
  for (genvar g = 1; g < DIGITS; g++) begin : g_sup
    assign w_suppress[g] = zero_suppress && !(|w_nz[DIGITS-1:g]);
  end

  if (BLANK == 0) begin : g_noblank
    assign w_show = 1'b1;
  end else begin : g_blank
    assign w_show = (r_cnt >= CW'(BLANK));
  end

  assign w_shifted   = r_active >> {r_slot, 2'b00};
  assign bcd         = w_shifted[3:0];
  assign digit_en    = w_show ? ((DIGITS'(1) << r_slot) & ~w_suppress) : '0;
  assign pending     = r_pending;
  assign frame_start = (r_cnt == '0) && (r_slot == '0);

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexed scan controller that shares a single BCD-to-seven-segment decoder across `DIGITS` common-anode/cathode digit positions. It holds a double-buffered multi-digit BCD value and steps through the digit positions at a fixed slot rate. For each slot it presents one BCD nibble to the decoder and drives a one-hot digit enable, with a blanking interval at the start of every slot to suppress ghosting. It sits between the counter/datapath producing BCD values and the shared decoder plus display pins.

## Interface
Parameters:
- `DIGITS`, 4, number of digit positions; legal range 1..8.
- `PRESCALE`, 1000, clock cycles per digit slot; must be ≥ 2.
- `BLANK`, 8, cycles at the start of each slot with all digit enables off; must satisfy 0 ≤ `BLANK` < `PRESCALE`.

Ports:
- `clk`  in  1  — the single clock; all state is rising-edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `load`  in  1  — captures `value` into the shadow register on this edge.
- `value`  in  4*DIGITS  — BCD digits; nibble i = digit i, digit 0 least significant.
- `zero_suppress`  in  1  — when 1, blanks leading zeros; used live (not registered).
- `bcd`  out  4  — nibble routed to the shared decoder.
- `digit_en`  out  DIGITS  — one-hot digit enable, active-high; all zero when blanked.
- `pending`  out  1  — shadow holds a value not yet displayed.
- `frame_start`  out  1  — high during the first cycle of slot 0.

## Operation
- **State:**
  - `cnt` runs 0..PRESCALE-1.
  - `slot` runs 0..DIGITS-1.
  - Registers `active[4*DIGITS]`, `shadow[4*DIGITS]` and `pending`.
- **Slot sequencing:**
  - `cnt` increments every cycle.
  - At `cnt == PRESCALE-1`, `cnt` returns to 0 and `slot` increments.
  - `slot` wraps from DIGITS-1 to 0.
- **Per-slot phases:**
  - BLANK phase (`cnt < BLANK`): `digit_en = 0`.
  - SHOW phase (`cnt ≥ BLANK`): `digit_en = 1<<slot`, unless that digit is suppressed.
- **Decoder drive:** `bcd = active[4*slot +: 4]` for the whole slot, including the blank phase, so the decoder settles before the enable asserts.
- **Load handling:**
  - `load` writes `shadow <= value` and sets `pending <= 1`.
  - A load while `pending` is already set overwrites `shadow`; the last load wins.
- **Frame boundary** (`cnt == PRESCALE-1 && slot == DIGITS-1`):
  - If `pending`, then `active <= shadow` and `pending <= 0`.
  - If `load` is asserted on this same cycle, then `active <= value`, `shadow <= value` and `pending` stays 0.
  - `active` never changes at any other time, so display updates are tear-free.
- **Leading-zero suppression:**
  - Digit i ≥ 1 is suppressed when `zero_suppress` = 1 and every `active` digit from i to DIGITS-1 equals 0.
  - Digit 0 is never suppressed.
  - Non-BCD nibbles (10..15) pass through unchanged and count as nonzero for suppression.
- **Outputs:** `frame_start = (cnt == 0 && slot == 0)`. All outputs are functions of registered state, except that `zero_suppress` gates `digit_en` combinationally.

## Timing
- **Reset** (async assert, sync release):
  - Registers: `cnt` = 0, `slot` = 0, `active` = 0, `shadow` = 0, `pending` = 0.
  - Outputs: `bcd` = 0, `digit_en` = 0, `pending` = 0, `frame_start` = 1.
- **After reset release:**
  - `digit_en` first asserts bit 0 after exactly `BLANK` edges; with `BLANK` = 0 it asserts immediately.
  - Reset asserted mid-slot returns to this state with no glitch beyond the async clear.
- **Timing figures:**
  - Frame length: DIGITS × PRESCALE cycles.
  - Each digit is lit for PRESCALE − BLANK cycles per frame.
- **Load-to-display latency:**
  - From a load edge to its first appearance on `bcd`: 1 to DIGITS × PRESCALE cycles.
  - The new value always starts at slot 0.
- `pending` rises on the edge after `load` and falls on the frame-boundary edge.

## Test plan
Scenarios 1–5 use DIGITS = 4, PRESCALE = 8, BLANK = 2.

1. **Reset:** hold `rst_n` = 0 → `digit_en` = 0000, `bcd` = 0, `pending` = 0, `frame_start` = 1. Release → `digit_en` = 0001 on cycles 2..7, then 0000 on cycles 8..9, then 0010.
2. **Scan order:** load `value` = 0x1234 and let one frame boundary pass → per 8-cycle slot, `bcd` shows 4, 3, 2, 1 and `digit_en` shows 0001, 0010, 0100, 1000 (each enable active on slot cycles 2..7); the frame is 32 cycles and `frame_start` pulses every 32 cycles.
3. **Tear-free update:** with 0x1234 active, load 0x5678 during slot 1 → `pending` = 1 and slots 1–3 still show 3, 2, 1. The next frame shows 8, 7, 6, 5 and `pending` returns to 0 at the boundary edge.
4. **Boundary loads:**
   - Load 0x9999 exactly at cnt = 7, slot = 3 → next frame shows 9s and `pending` never rises.
   - Two loads in one frame (0x1111, then 0x2222) → 0x2222 is displayed.
5. **Zero suppression:**
   - `value` = 0x0040, `zero_suppress` = 1 → slots 2 and 3 keep `digit_en` = 0; slot 0 shows 0 and slot 1 shows 4.
   - `value` = 0x0000 → only digit 0 is lit.
   - `value` = 0x0A00 → digit 2 is lit.
   - Toggling `zero_suppress` to 0 relights digits on the same cycle.
6. **Edge parameters** (DIGITS = 1, BLANK = 0, PRESCALE = 2): `digit_en` = 1 continuously and `frame_start` toggles every cycle. Async reset asserted at cnt = 5 of slot 2 in the default configuration clears all state immediately.
